// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with bubble/flush; `define PIPE_STAGE_SKID_EN for a
// two-entry skid buffer with flop-driven in_ready/out_valid/count.
module pipe_stage_reg #(
  parameter int WIDTH = 65,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic in_fire, out_fire;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] main_q, main_n, skid_q, skid_n;
  // state encoding doubles as the entry count
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign count = state;
  assign out_data = main_q;
  always_comb begin
    state_n = state;
    main_n = main_q;
    skid_n = skid_q;
    case (state)
      EMPTY: if (in_fire) begin
        state_n = ONE;
        main_n = in_data;
      end
      ONE: if (in_fire && out_fire) main_n = in_data;
      else if (in_fire) begin
        state_n = TWO;
        skid_n = in_data;
      end else if (out_fire) begin
        state_n = EMPTY;
        main_n = RESET_DATA;
      end
      default: if (out_fire) begin
        state_n = ONE;
        main_n = skid_q;
        skid_n = RESET_DATA;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= EMPTY;
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      state <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end
`else
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  assign in_ready = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign count = {1'b0, valid_q};
  assign out_data = data_q;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      data_q <= RESET_DATA;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      data_q <= in_data;
    end else if (out_fire) begin
      valid_q <= 1'b0;
      data_q <= RESET_DATA;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random scoreboard bench for pipe_stage_reg (65- and 8-bit instances).
module tb_pipe_stage_reg;
  localparam logic [64:0] RD = 65'h1_0000_0000_0000_0013;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [64:0] in_data = '0;
  logic in_ready, out_valid, in_ready8, out_valid8;
  logic [64:0] out_data;
  logic [7:0] out_data8;
  logic [1:0] count, count8;
  int n_tests = 0, n_fail = 0;
  logic [64:0] q[$];
  logic stall_prev = 1'b0;
  logic [64:0] prev_data = '0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(65), .RESET_DATA(RD)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
  );
  pipe_stage_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data[7:0]), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .count(count8)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset || flush) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      check("count", 65'(count), 65'(q.size()));
      if (out_valid) begin
        if (q.size() == 0) check("spurious", 65'd1, 65'd0);
        else check("head", out_data, q[0]);
      end else check("bubble", out_data, RD);
      if (stall_prev) check("stall", out_data, prev_data);
`ifdef PIPE_STAGE_SKID_EN
      check("ready", 65'(in_ready), 65'(q.size() != 2));
`else
      check("ready", 65'(in_ready), 65'(!out_valid || out_ready));
`endif
      check("w8_valid", 65'(out_valid8), 65'(out_valid));
      check("w8_ready", 65'(in_ready8), 65'(in_ready));
      check("w8_count", 65'(count8), 65'(count));
      check("w8_data", 65'(out_data8), 65'(out_valid ? out_data[7:0] : 8'h0));
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(in_data);
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_valid", 65'(out_valid), 65'd0);
    check("rst_data", out_data, RD);
    check("rst_count", 65'(count), 65'd0);
    check("rst_ready", 65'(in_ready), 65'd1);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 65'(i);
      cyc();
      check("stream_valid", 65'(out_valid), 65'd1);
      check("stream_data", out_data, 65'(i));
      check("stream_count", 65'(count), 65'd1);
    end
    in_valid = 1'b0;
    cyc();
    in_valid = 1'b1;
    in_data = 65'h55;
    cyc();
    check("drain_head", out_data, 65'h55);
    in_valid = 1'b0;
    cyc();
    check("drain_valid", 65'(out_valid), 65'd0);
    check("drain_data", out_data, RD);
`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 65'hA;
    cyc();
    in_data = 65'hB;
    cyc();
    check("fill_count", 65'(count), 65'd2);
    check("fill_ready", 65'(in_ready), 65'd0);
    check("fill_data", out_data, 65'hA);
    in_data = 65'hC;
    cyc();
    check("hold_count", 65'(count), 65'd2);
    check("hold_data", out_data, 65'hA);
    out_ready = 1'b1;
    cyc();
    check("rel_b", out_data, 65'hB);
    check("rel_count", 65'(count), 65'd1);
    cyc();
    check("rel_c", out_data, 65'hC);
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 65'hE;
    cyc();
    in_data = 65'hF;
    cyc();
    check("pre_flush_count", 65'(count), 65'd2);
`else
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 65'hA;
    cyc();
    in_valid = 1'b0;
    check("ns_count", 65'(count), 65'd1);
    check("ns_data", out_data, 65'hA);
    check("ns_ready_lo", 65'(in_ready), 65'd0);
    out_ready = 1'b1;
    #1;
    check("ns_ready_hi", 65'(in_ready), 65'd1);
    out_ready = 1'b0;
    cyc();
    check("ns_stall", out_data, 65'hA);
`endif
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 65'hD;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 65'(out_valid), 65'd0);
    check("flush_data", out_data, RD);
    check("flush_count", 65'(count), 65'd0);
    check("flush_ready", 65'(in_ready), 65'd1);
    cyc();
    check("flush_no_d", 65'(out_valid), 65'd0);
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      in_data = {$urandom(), $urandom(), 1'($urandom())};
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check("drained", 65'(q.size()), 65'd0);
    check("end_valid", 65'(out_valid), 65'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
